// File: rtl/msrv32_dmem_responder.sv
// Data-memory slave for the core's AHB-lite-style data port: word-organised array,
// configurable wait states, and a two-cycle ERROR response for addresses outside the array.
module msrv32_dmem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] haddr_in,
    input  logic [1:0]  htrans_in,
    input  logic        wr_req_in,
    input  logic [3:0]  wr_mask_in,
    input  logic [31:0] wdata_in,
    output logic [31:0] rdata_out,
    output logic        hready_out,
    output logic        hresp_out
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic                    r_wr;
    logic [3:0]              r_mask;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rdata;
    logic                    r_hready;
    logic                    r_hresp;
    logic [31:0]             r_mem [DEPTH];

    logic w_accept;
    logic w_in_range;
    logic w_commit;
    logic w_rd_data;
    logic w_unused;

    // BASE_ADDR is aligned to the array size, so the range test reduces to the upper bits.
    assign w_in_range = (haddr_in[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign w_accept   = r_hready && htrans_in[1];
    assign w_commit   = (r_state == S_DATA) && r_wr;
    assign w_rd_data  = (r_state == S_DATA) && !r_wr;
    assign w_unused   = ^{haddr_in[1:0], htrans_in[0]};

    // During a read data phase the array is presented directly, so a write committed at the
    // previous edge is already visible; r_rdata captures it at the end of the phase and holds.
    assign rdata_out  = w_rd_data ? r_mem[r_idx] : r_rdata;
    assign hready_out = r_hready;
    assign hresp_out  = r_hresp;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_idx    <= '0;
            r_wr     <= 1'b0;
            r_mask   <= 4'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= S_DATA;
                        r_hready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state  <= S_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 all sit with hready high and accept a new address phase.
                    if (w_rd_data) begin
                        r_rdata <= r_mem[r_idx];
                    end
                    if (w_accept) begin
                        r_idx   <= haddr_in[ADDR_WIDTH+1:2];
                        r_wr    <= wr_req_in;
                        r_mask  <= wr_mask_in;
                        r_wdata <= wdata_in;
                        if (!w_in_range) begin
                            r_state  <= S_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            r_state  <= S_DATA;
                            r_hready <= 1'b1;
                            r_hresp  <= 1'b0;
                        end else begin
                            r_state  <= S_WAIT;
                            r_cnt    <= WAIT_LOAD;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b0;
                        end
                    end else begin
                        r_state  <= S_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Array is never reset; a reset forces IDLE asynchronously, so no pending write survives it.
    always_ff @(posedge clk_in) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_mask[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// Directed bench for msrv32_dmem_responder: three instances with 0, 1 and 3 wait states
// share the address-phase bus; htrans is steered to one instance at a time.
module tb_msrv32_dmem_responder;
    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] wdata;

    logic [1:0]  tr0, tr1, tr3;
    logic [31:0] rdata0, rdata1, rdata3;
    logic        hready0, hready1, hready3;
    logic        hresp0, hresp1, hresp3;
    logic [31:0] rdata;
    logic        hready;
    logic        hresp;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    assign tr0 = (sel == 2'd0) ? htrans : 2'b00;
    assign tr1 = (sel == 2'd1) ? htrans : 2'b00;
    assign tr3 = (sel == 2'd3) ? htrans : 2'b00;

    assign rdata  = (sel == 2'd0) ? rdata0  : (sel == 2'd1) ? rdata1  : rdata3;
    assign hready = (sel == 2'd0) ? hready0 : (sel == 2'd1) ? hready1 : hready3;
    assign hresp  = (sel == 2'd0) ? hresp0  : (sel == 2'd1) ? hresp1  : hresp3;

    msrv32_dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(0)) u_w0 (
        .clk_in(clk), .rst_in(rst_n), .haddr_in(haddr), .htrans_in(tr0), .wr_req_in(wr),
        .wr_mask_in(mask), .wdata_in(wdata), .rdata_out(rdata0), .hready_out(hready0),
        .hresp_out(hresp0));

    msrv32_dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(1)) u_w1 (
        .clk_in(clk), .rst_in(rst_n), .haddr_in(haddr), .htrans_in(tr1), .wr_req_in(wr),
        .wr_mask_in(mask), .wdata_in(wdata), .rdata_out(rdata1), .hready_out(hready1),
        .hresp_out(hresp1));

    msrv32_dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(3)) u_w3 (
        .clk_in(clk), .rst_in(rst_n), .haddr_in(haddr), .htrans_in(tr3), .wr_req_in(wr),
        .wr_mask_in(mask), .wdata_in(wdata), .rdata_out(rdata3), .hready_out(hready3),
        .hresp_out(hresp3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one address phase, then idle the bus until hready returns (bounded).
    // Returns in the completing cycle (DATA or ERR2) with the cycle count in cyc.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] m,
                        input logic [31:0] d, output int cyc);
        haddr  = a;
        wr     = w;
        mask   = m;
        wdata  = d;
        htrans = 2'b10;
        tick();
        htrans = 2'b00;
        cyc    = 1;
        while (!hready && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!hready) chk("xfer_timeout", 32'(hready), 32'd1);
    endtask

    initial begin
        rst_n  = 1'b1;
        sel    = 2'd1;
        htrans = 2'b00;
        haddr  = 32'd0;
        wr     = 1'b0;
        mask   = 4'd0;
        wdata  = 32'd0;

        // Asynchronous reset, checked before any clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("rst_hready", 32'(hready), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("idle_hready", 32'(hready), 32'd1);

        // One wait state: preload and latency
        xfer(32'h2000, 1'b1, 4'hF, 32'hCAFE_F00D, lat);
        chk("w1_wr_latency", 32'(lat), 32'd2);
        tick();
        xfer(32'h2004, 1'b1, 4'hF, 32'hDEAD_BEEF, lat);
        tick();

        // Read with one wait state; inputs wiggled during the wait must be ignored
        haddr  = 32'h2004;
        wr     = 1'b0;
        htrans = 2'b10;
        tick();
        chk("rd_wait_hready", 32'(hready), 32'd0);
        chk("rd_wait_hresp", 32'(hresp), 32'd0);
        htrans = 2'b00;
        haddr  = 32'h0000_1000;
        wr     = 1'b1;
        tick();
        chk("rd_data_hready", 32'(hready), 32'd1);
        chk("rd_data_hresp", 32'(hresp), 32'd0);
        chk("rd_data_rdata", rdata, 32'hDEAD_BEEF);
        tick();
        chk("rd_hold_rdata", rdata, 32'hDEAD_BEEF);

        // Masked writes
        xfer(32'h2008, 1'b1, 4'hF, 32'h1122_3344, lat);
        tick();
        xfer(32'h2008, 1'b1, 4'b0101, 32'hAABB_CCDD, lat);
        tick();
        xfer(32'h2008, 1'b0, 4'h0, 32'h0, lat);
        chk("mask0101_rdata", rdata, 32'h11BB_33DD);
        tick();
        xfer(32'h2008, 1'b1, 4'b0000, 32'hFFFF_FFFF, lat);
        tick();
        xfer(32'h2008, 1'b0, 4'h0, 32'h0, lat);
        chk("mask0000_rdata", rdata, 32'h11BB_33DD);
        tick();

        // Last word of the array is in range
        xfer(32'h2FFC, 1'b1, 4'hF, 32'hA5A5_0FFC, lat);
        chk("top_wr_hresp", 32'(hresp), 32'd0);
        tick();
        xfer(32'h2FFC, 1'b0, 4'h0, 32'h0, lat);
        chk("top_rd_rdata", rdata, 32'hA5A5_0FFC);
        tick();

        // Out-of-range write below the array: ERR1, ERR2, then accept in ERR2
        haddr  = 32'h0000_1000;
        wr     = 1'b1;
        mask   = 4'hF;
        wdata  = 32'hBAD0_BAD0;
        htrans = 2'b10;
        tick();
        chk("err1_hready", 32'(hready), 32'd0);
        chk("err1_hresp", 32'(hresp), 32'd1);
        chk("err1_rdata", rdata, 32'hA5A5_0FFC);
        htrans = 2'b00;
        tick();
        chk("err2_hready", 32'(hready), 32'd1);
        chk("err2_hresp", 32'(hresp), 32'd1);
        haddr  = 32'h2000;
        wr     = 1'b0;
        htrans = 2'b10;
        tick();
        chk("err2_accept_hready", 32'(hready), 32'd0);
        chk("err2_accept_hresp", 32'(hresp), 32'd0);
        htrans = 2'b00;
        tick();
        chk("after_err_rdata", rdata, 32'hCAFE_F00D);
        chk("after_err_hresp", 32'(hresp), 32'd0);
        tick();

        // Out-of-range read just past the top of the array
        xfer(32'h3000, 1'b0, 4'h0, 32'h0, lat);
        chk("err_top_latency", 32'(lat), 32'd2);
        chk("err_top_hresp", 32'(hresp), 32'd1);
        chk("err_top_rdata", rdata, 32'hCAFE_F00D);
        tick();
        chk("err_top_idle_hresp", 32'(hresp), 32'd0);

        // Zero wait states: write followed by a pipelined read of the same word
        sel = 2'd0;
        haddr  = 32'h2010;
        wr     = 1'b1;
        mask   = 4'hF;
        wdata  = 32'h1234_5678;
        htrans = 2'b10;
        tick();
        chk("pipe_wr_hready", 32'(hready), 32'd1);
        wr     = 1'b0;
        wdata  = 32'd0;
        tick();
        chk("pipe_rd_hready", 32'(hready), 32'd1);
        chk("pipe_rd_hresp", 32'(hresp), 32'd0);
        chk("pipe_rd_rdata", rdata, 32'h1234_5678);
        htrans = 2'b00;
        tick();
        xfer(32'h2014, 1'b0, 4'h0, 32'h0, lat);
        chk("w0_latency", 32'(lat), 32'd1);
        tick();

        // Three wait states: reset asserted while a write is pending
        sel = 2'd3;
        xfer(32'h2020, 1'b1, 4'hF, 32'h55AA_55AA, lat);
        chk("w3_latency", 32'(lat), 32'd4);
        tick();
        xfer(32'h2020, 1'b0, 4'h0, 32'h0, lat);
        chk("w3_rd_rdata", rdata, 32'h55AA_55AA);
        tick();
        haddr  = 32'h2020;
        wr     = 1'b1;
        mask   = 4'hF;
        wdata  = 32'hFFFF_FFFF;
        htrans = 2'b10;
        tick();
        chk("w3_pend_hready", 32'(hready), 32'd0);
        htrans = 2'b00;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_hready", 32'(hready), 32'd1);
        chk("midrst_hresp", 32'(hresp), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_hready", 32'(hready), 32'd1);
        xfer(32'h2020, 1'b0, 4'h0, 32'h0, lat);
        chk("midrst_word_kept", rdata, 32'h55AA_55AA);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/msrv32_dmem_responder.md
Name: msrv32_dmem_responder

Overview:
- AHB-lite-style data-memory responder: the slave end of the core's data port.
- Accepts address phases (address, htrans, write request, byte mask, write data) and inserts a configurable number of wait states.
- Returns read data or commits masked writes, and signals errors for out-of-range addresses with the two-cycle ERROR response.
- Contains a single-port word-organised memory array. Sits between the core's data-port outputs and its data_hready/hresp/data inputs.

Parameters:
- ADDR_WIDTH, 10: word-address bits; array depth 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_2000: byte base address of the array; must be aligned to the array size.
- WAIT_STATES, 1: wait cycles per OKAY transfer, 0..15.

Ports:
- clk_in, input, 1: clock; all state changes on the rising edge.
- rst_in, input, 1: reset, asynchronous, active-low.
- haddr_in, input, 32: byte address (address phase).
- htrans_in, input, 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- wr_req_in, input, 1: 1 = write, 0 = read (address phase).
- wr_mask_in, input, 4: byte-lane write enables (address phase).
- wdata_in, input, 32: write data, captured with the address phase.
- rdata_out, output, 32: read data, valid when hready_out=1 ending a read data phase.
- hready_out, output, 1: transfer complete / address phase accepted.
- hresp_out, output, 1: 0 OKAY, 1 ERROR.

Behaviour:
- Reset (rst_in=0, async): state=IDLE, hready_out=1, hresp_out=0, rdata_out=0, wait counter=0, captured registers cleared. Array contents are not cleared.
- Acceptance: an address phase is accepted on any rising edge where hready_out=1 and htrans_in[1]=1. On acceptance, register haddr_in, wr_req_in, wr_mask_in and wdata_in.
- IDLE/BUSY with hready_out=1: no transfer; the next cycle is zero-wait OKAY.
- In-range test: BASE_ADDR <= haddr_in < BASE_ADDR + 4*2^ADDR_WIDTH.
- Word index is (haddr_in - BASE_ADDR)[ADDR_WIDTH+1:2]. haddr_in[1:0] is ignored; alignment is the master's responsibility.
- States:
  - IDLE: hready_out=1, hresp_out=0. Accepted in-range transfer -> WAIT (WAIT_STATES>0, counter loaded with WAIT_STATES-1) or DATA (WAIT_STATES=0). Out-of-range -> ERR1.
  - WAIT: hready_out=0, hresp_out=0. Counter decrements each cycle; at 0 -> DATA.
  - DATA: hready_out=1, hresp_out=0. For a read, rdata_out = array[captured index]. For a write, each byte lane i with mask[i]=1 is written at the end-of-cycle edge; mask 0000 writes nothing. A new address phase may be accepted in the same cycle (pipelined), taking the same transitions as IDLE; otherwise -> IDLE.
  - ERR1: hready_out=0, hresp_out=1; -> ERR2. The write is discarded and the array is unchanged.
  - ERR2: hready_out=1, hresp_out=1. Any address phase presented here is accepted as from IDLE.
- rdata_out is registered. It updates only on read completion and holds its value otherwise, including across writes and errors.
- Read-after-write to the same word, back-to-back: the write commits at the edge ending its DATA cycle, before the read's data phase, so the read returns the new data. No forwarding path is required.
- htrans_in, haddr_in and other inputs are ignored while hready_out=0.
- Reset asserted mid-transfer aborts the transfer, and a pending write is not committed.
- Latency: OKAY transfer completes WAIT_STATES+1 cycles after acceptance. Error completes 2 cycles after acceptance.

Test Plan:
- Reset: rst_in=0 asserted asynchronously mid-cycle -> hready_out=1, hresp_out=0, rdata_out=0 immediately; state IDLE after release.
- Read with WAIT_STATES=1: preload word 0x2004=0xDEADBEEF; NONSEQ read at 0x2004 -> hready_out=0 for 1 cycle, then hready_out=1, rdata_out=0xDEADBEEF, hresp_out=0.
- Masked write: word 0x2008=0x11223344; write 0xAABBCCDD with mask 0101, then read 0x2008 -> 0x11BB33DD. Mask 0000 write -> word unchanged.
- Pipelined write then read, WAIT_STATES=0: write 0x12345678 to 0x2010, NONSEQ read 0x2010 in its DATA cycle -> read completes next cycle with 0x12345678; no idle cycle between the two.
- Error: read or write at 0x0000_1000 -> ERR1 (hready_out=0, hresp_out=1), ERR2 (hready_out=1, hresp_out=1); array unchanged; rdata_out keeps its previous value; a NONSEQ at 0x2000 presented in ERR2 is accepted.
- Reset mid-WAIT with WAIT_STATES=3: pulse rst_in low during a pending write to 0x2020 -> word unchanged; hready_out=1 immediately.
